h14tx_encoding: RTL and testbench
=================================

# h14tx_encoding

Per-lane HDMI 1.4 TMDS symbol encoder. Each instance serves one of the three TMDS data channels. Every clock it converts the current period type and that lane's control, TERC4 data or video byte into one registered 10-bit symbol. It sits between the period/packet scheduler and the 10:1 serializer; three instances (Chan = 0, 1, 2) share one `period` input.

## Interface
- `Chan`, default 0 — lane index 0..2; selects guard-band and preamble constants.
- `clk`  in  1 — pixel clock; one clock for the whole block.
- `rst_n`  in  1 — reset, named as in the codebase. Reset is synchronous and active-high: a 1 on this port resets the block.
- `ctl`  in  2 (`ctl_t`) — control bits. Lane 0 carries {vsync, hsync}; lanes 1 and 2 carry CTL1:0 and CTL3:2.
- `data`  in  4 (`data_t`) — TERC4 nibble for data-island payload.
- `video`  in  8 (`video_t`) — pixel byte for this lane.
- `period`  in  3 (`period_t`) — current period type.
- `symbol`  out  10 (`symbol_t`) — encoded symbol. Bit 0 is transmitted first.

## Operation
- Control: output the control token for `ctl`.
  - 00 → 1101010100
  - 01 → 0010101011
  - 10 → 0101010100
  - 11 → 1010101011
- VideoPreamble: output a control token. Lane 0 uses `ctl`; lane 1 is forced to 01; lane 2 is forced to 00.
- DataIslandPreamble: output a control token. Lane 0 uses `ctl`; lanes 1 and 2 are forced to 01.
- VideoGuard:
  - lanes 0 and 2: 1011001100
  - lane 1: 0100110011
- DataIslandGuard:
  - lanes 1 and 2: 0100110011
  - lane 0: TERC4({2'b11, `ctl`})
- DataIslandActive: TERC4(`data`), mapped as follows:
  - 0→1010011100, 1→1001100011, 2→1011100100, 3→1011100010
  - 4→0101110001, 5→0100011110, 6→0110001110, 7→0100111100
  - 8→1011001100, 9→0100111001, A→0110011100, B→1011000110
  - C→1010001110, D→1001110001, E→0101100011, F→1011000011
- VideoActive: DVI 8b/10b encoding with DC balance.
  - N1 = number of ones in `video`. Use XNOR when N1 > 4, or when N1 == 4 and video[0] == 0; otherwise use XOR.
  - q_m[0] = video[0]; q_m[i] = q_m[i-1] op video[i] for i = 1..7; q_m[8] = 1 for XOR, 0 for XNOR.
  - n1/n0 = count of ones/zeros in q_m[7:0].
  - Case A, cnt == 0 or n1 == n0: q = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}. cnt += q_m[8] ? (n1 − n0) : (n0 − n1).
  - Case B, (cnt > 0 and n1 > n0) or (cnt < 0 and n0 > n1): q = {1, q_m[8], ~q_m[7:0]}. cnt += 2·q_m[8] + (n0 − n1).
  - Case C, otherwise: q = {0, q_m[8], q_m[7:0]}. cnt += −2·(~q_m[8]) + (n1 − n1's complement count, i.e. n1 − n0).
  - cnt is a 5-bit signed running disparity. It is updated only on VideoActive cycles. It is cleared to 0 on every cycle where `period` is not VideoActive.
- Unused inputs are ignored in each period.
- Unknown or illegal `period` codes are treated as Control.

## Timing
- Latency: 1 clock. `symbol` at edge k+1 reflects inputs sampled at edge k.
- Reset (synchronous, active-high on `rst_n`): `symbol` = 1101010100 and cnt = 0 on the next edge. Reset wins over all inputs.
- Reset asserted in the middle of video: the stream restarts with cnt = 0.
- Period switches take effect on the very next symbol, with no settling cycles.
- The first VideoActive cycle after any other period starts from cnt = 0.

## Structure
- Package `h14tx_pkg` holds:
  - typedefs `period_t`, `symbol_t`, `ctl_t`, `data_t`, `video_t`
  - `period_t` encoding: Control = 0, VideoActive = 1, VideoPreamble = 2, VideoGuard = 3, DataIslandActive = 4, DataIslandPreamble = 5, DataIslandGuard = 6
  - the control-token, guard-band and TERC4 constants and functions
- Sub-module `h14tx_tmds_video_enc` contains the 8b/10b encoder and the cnt register. The top level does period muxing and the output register.

## Test plan
- Reset, then Control with ctl = 00 → 1101010100. Then ctl = 10 on lane 2 → 0101010100; ctl = 01 on lanes 1 and 2 → 0010101011.
- DataIslandPreamble → lanes 1 and 2 give 0010101011. DataIslandGuard → lanes 1 and 2 give 0100110011; lane 0 with ctl = 00 gives TERC4(1100) = 1010001110.
- DataIslandActive:
  - data 0111 on lane 2 → 0100111100
  - data {1101, 1000, 0001} on lanes 2, 1, 0 → 1001110001, 1011001100, 1001100011
- VideoPreamble → lane 1 gives 0010101011 and lane 2 gives 1101010100. VideoGuard → lanes 0, 1, 2 give 1011001100, 0100110011, 1011001100.
- VideoActive from cnt = 0:
  - video 0x00 → 0100000000, cnt = −8
  - next 0x00 → 1111111111, cnt = +2
  - separately, fresh cnt with 0xFF → 1000000000, cnt = −8
- Mixed sequence FF/00 per lane, then back to Control: the symbol matches a reference model each cycle, and cnt is 0 after leaving video.

Source files
------------

// File: rtl/h14tx_pkg.sv
// Shared types and TMDS constants for the HDMI 1.4 lane encoder.
package h14tx_pkg;

    typedef enum logic [2:0] {
        PERIOD_CONTROL        = 3'd0,
        PERIOD_VIDEO_ACTIVE   = 3'd1,
        PERIOD_VIDEO_PREAMBLE = 3'd2,
        PERIOD_VIDEO_GUARD    = 3'd3,
        PERIOD_DATA_ACTIVE    = 3'd4,
        PERIOD_DATA_PREAMBLE  = 3'd5,
        PERIOD_DATA_GUARD     = 3'd6
    } period_t;

    typedef logic [9:0] symbol_t;
    typedef logic [1:0] ctl_t;
    typedef logic [3:0] data_t;
    typedef logic [7:0] video_t;

    // Symbols are written MSB (bit 9) first; bit 0 goes on the wire first.
    localparam symbol_t CTL_TOKEN_00 = 10'b1101010100;
    localparam symbol_t CTL_TOKEN_01 = 10'b0010101011;
    localparam symbol_t CTL_TOKEN_10 = 10'b0101010100;
    localparam symbol_t CTL_TOKEN_11 = 10'b1010101011;

    localparam symbol_t GUARD_VIDEO_LANE02 = 10'b1011001100;
    localparam symbol_t GUARD_VIDEO_LANE1  = 10'b0100110011;
    localparam symbol_t GUARD_DATA_LANE12  = 10'b0100110011;

    function automatic symbol_t ctl_token(input ctl_t c);
        symbol_t s;
        case (c)
            2'b00:   s = CTL_TOKEN_00;
            2'b01:   s = CTL_TOKEN_01;
            2'b10:   s = CTL_TOKEN_10;
            default: s = CTL_TOKEN_11;
        endcase
        return s;
    endfunction

    function automatic symbol_t terc4(input data_t d);
        symbol_t s;
        case (d)
            4'h0:    s = 10'b1010011100;
            4'h1:    s = 10'b1001100011;
            4'h2:    s = 10'b1011100100;
            4'h3:    s = 10'b1011100010;
            4'h4:    s = 10'b0101110001;
            4'h5:    s = 10'b0100011110;
            4'h6:    s = 10'b0110001110;
            4'h7:    s = 10'b0100111100;
            4'h8:    s = 10'b1011001100;
            4'h9:    s = 10'b0100111001;
            4'hA:    s = 10'b0110011100;
            4'hB:    s = 10'b1011000110;
            4'hC:    s = 10'b1010001110;
            4'hD:    s = 10'b1001110001;
            4'hE:    s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/h14tx_encoding_video_enc.sv
// DVI 8b/10b video encoder with the running-disparity register.
module h14tx_tmds_video_enc
    import h14tx_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en,
    input  video_t  video,
    output symbol_t q
);

    logic signed [4:0] cnt;
    logic signed [4:0] cnt_next;
    logic signed [4:0] diff;
    logic [3:0]        n1_video;
    logic [3:0]        n1_qm;
    logic              use_xnor;
    logic              qm8;
    logic [7:0]        qm;
    logic              balanced;

    assign n1_video = ones8(video);
    assign use_xnor = (n1_video > 4'd4) || ((n1_video == 4'd4) && !video[0]);
    assign qm8      = ~use_xnor;

    // Transition-minimising chain built in a block-local variable.
    always_comb begin
        logic [7:0] m;
        m    = 8'd0;
        m[0] = video[0];
        for (int i = 1; i < 8; i++) begin
            m[i] = use_xnor ? ~(m[i-1] ^ video[i]) : (m[i-1] ^ video[i]);
        end
        qm = m;
    end

    assign n1_qm    = ones8(qm);
    assign balanced = (n1_qm == 4'd4);
    // n1 - n0 = 2*n1 - 8; wraps harmlessly in 5 bits since the result is in -8..8.
    assign diff     = $signed({n1_qm, 1'b0}) - 5'sd8;

    // DC-balance decision and next running disparity.
    always_comb begin
        q        = '0;
        cnt_next = cnt;
        if ((cnt == 5'sd0) || balanced) begin
            q        = {~qm8, qm8, (qm8 ? qm : ~qm)};
            cnt_next = qm8 ? (cnt + diff) : (cnt - diff);
        end else if ((!cnt[4] && (n1_qm > 4'd4)) || (cnt[4] && (n1_qm < 4'd4))) begin
            q        = {1'b1, qm8, ~qm};
            cnt_next = cnt - diff + (qm8 ? 5'sd2 : 5'sd0);
        end else begin
            q        = {1'b0, qm8, qm};
            cnt_next = cnt + diff - (qm8 ? 5'sd0 : 5'sd2);
        end
    end

    // Disparity only survives across consecutive video-active cycles.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt <= 5'sd0;
        end else if (en) begin
            cnt <= cnt_next;
        end else begin
            cnt <= 5'sd0;
        end
    end

endmodule

// File: rtl/h14tx_encoding.sv
// Per-lane TMDS symbol encoder: period muxing plus the output register.
module h14tx_encoding
    import h14tx_pkg::*;
#(
    parameter int Chan = 0
) (
    input  logic    clk,
    input  logic    rst_n,
    input  ctl_t    ctl,
    input  data_t   data,
    input  video_t  video,
    input  period_t period,
    output symbol_t symbol
);

    logic    video_en;
    symbol_t video_sym;
    symbol_t next_sym;

    assign video_en = (period == PERIOD_VIDEO_ACTIVE);

    h14tx_tmds_video_enc u_video_enc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (video_en),
        .video (video),
        .q     (video_sym)
    );

    // Select the symbol for the current period; unlisted codes fall back to control.
    always_comb begin
        next_sym = ctl_token(ctl);
        case (period)
            PERIOD_VIDEO_ACTIVE:   next_sym = video_sym;
            PERIOD_VIDEO_PREAMBLE: begin
                if (Chan == 1)      next_sym = CTL_TOKEN_01;
                else if (Chan == 2) next_sym = CTL_TOKEN_00;
                else                next_sym = ctl_token(ctl);
            end
            PERIOD_VIDEO_GUARD:    next_sym = (Chan == 1) ? GUARD_VIDEO_LANE1 : GUARD_VIDEO_LANE02;
            PERIOD_DATA_ACTIVE:    next_sym = terc4(data);
            PERIOD_DATA_PREAMBLE:  next_sym = (Chan == 0) ? ctl_token(ctl) : CTL_TOKEN_01;
            PERIOD_DATA_GUARD:     next_sym = (Chan == 0) ? terc4({2'b11, ctl}) : GUARD_DATA_LANE12;
            default:               next_sym = ctl_token(ctl);
        endcase
    end

    // One-clock registered output; reset overrides every input.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            symbol <= CTL_TOKEN_00;
        end else begin
            symbol <= next_sym;
        end
    end

endmodule

// File: tb/tb_h14tx_encoding.sv
// Directed bench for three encoder lanes sharing one period input.
module tb_h14tx_encoding;
    import h14tx_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n;
    period_t period;
    ctl_t    ctl0, ctl1, ctl2;
    data_t   d0, d1, d2;
    video_t  v0, v1, v2;
    symbol_t sym0, sym1, sym2;

    int n_chk  = 0;
    int n_pass = 0;
    int mcnt [3];

    logic [7:0] tbl [0:15] = '{8'hFF, 8'h00, 8'hA5, 8'h3C, 8'h10, 8'hFE,
                               8'h81, 8'h7F, 8'h55, 8'h0F, 8'hC3, 8'h01,
                               8'hEE, 8'h24, 8'h99, 8'h6B};

    always #5 clk = ~clk;

    h14tx_encoding #(.Chan(0)) u_lane0 (.clk(clk), .rst_n(rst_n), .ctl(ctl0), .data(d0),
                                        .video(v0), .period(period), .symbol(sym0));
    h14tx_encoding #(.Chan(1)) u_lane1 (.clk(clk), .rst_n(rst_n), .ctl(ctl1), .data(d1),
                                        .video(v1), .period(period), .symbol(sym1));
    h14tx_encoding #(.Chan(2)) u_lane2 (.clk(clk), .rst_n(rst_n), .ctl(ctl2), .data(d2),
                                        .video(v2), .period(period), .symbol(sym2));

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %b want %b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference 8b/10b written from the encoding rules with plain integers.
    function automatic logic [9:0] ref_enc(input logic [7:0] v, input int cin, output int cout);
        int         nv, ones, zeros;
        logic [7:0] m;
        logic       xn, m8;
        nv = 0;
        for (int i = 0; i < 8; i++) nv += int'(v[i]);
        xn   = (nv > 4) || (nv == 4 && v[0] == 1'b0);
        m[0] = v[0];
        for (int i = 1; i < 8; i++) m[i] = xn ? ~(m[i-1] ^ v[i]) : (m[i-1] ^ v[i]);
        m8 = !xn;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(m[i]);
        zeros = 8 - ones;
        if (cin == 0 || ones == zeros) begin
            cout = m8 ? cin + ones - zeros : cin + zeros - ones;
            return {~m8, m8, m8 ? m : ~m};
        end else if ((cin > 0 && ones > zeros) || (cin < 0 && zeros > ones)) begin
            cout = cin + 2 * int'(m8) + zeros - ones;
            return {1'b1, m8, ~m};
        end else begin
            cout = cin - 2 * int'(!m8) + ones - zeros;
            return {1'b0, m8, m};
        end
    endfunction

    initial begin
        logic [9:0] e0, e1, e2;
        int         c;

        rst_n = 1'b1; period = PERIOD_VIDEO_GUARD;
        ctl0 = 2'b11; ctl1 = 2'b11; ctl2 = 2'b11;
        d0 = 4'h0; d1 = 4'h0; d2 = 4'h0;
        v0 = 8'hFF; v1 = 8'hFF; v2 = 8'hFF;
        tick(); tick();
        chk("reset_l0", sym0, 10'b1101010100);
        chk("reset_l1", sym1, 10'b1101010100);
        chk("reset_l2", sym2, 10'b1101010100);

        rst_n = 1'b0; period = PERIOD_CONTROL; ctl0 = 2'b00; ctl1 = 2'b00; ctl2 = 2'b00;
        tick();
        chk("ctl00_l0", sym0, 10'b1101010100);

        ctl0 = 2'b11; ctl1 = 2'b01; ctl2 = 2'b10;
        tick();
        chk("ctl11_l0", sym0, 10'b1010101011);
        chk("ctl01_l1", sym1, 10'b0010101011);
        chk("ctl10_l2", sym2, 10'b0101010100);

        ctl2 = 2'b01;
        tick();
        chk("ctl01_l2", sym2, 10'b0010101011);

        period = PERIOD_DATA_PREAMBLE; ctl0 = 2'b00; ctl1 = 2'b00; ctl2 = 2'b10;
        tick();
        chk("dipre_l0", sym0, 10'b1101010100);
        chk("dipre_l1", sym1, 10'b0010101011);
        chk("dipre_l2", sym2, 10'b0010101011);

        period = PERIOD_DATA_GUARD; ctl0 = 2'b00;
        tick();
        chk("diguard_l0", sym0, 10'b1010001110);
        chk("diguard_l1", sym1, 10'b0100110011);
        chk("diguard_l2", sym2, 10'b0100110011);

        ctl0 = 2'b01;
        tick();
        chk("diguard01_l0", sym0, 10'b1001110001);

        period = PERIOD_DATA_ACTIVE; d2 = 4'b0111;
        tick();
        chk("terc4_7_l2", sym2, 10'b0100111100);

        d2 = 4'b1101; d1 = 4'b1000; d0 = 4'b0001;
        tick();
        chk("terc4_d_l2", sym2, 10'b1001110001);
        chk("terc4_8_l1", sym1, 10'b1011001100);
        chk("terc4_1_l0", sym0, 10'b1001100011);

        period = PERIOD_VIDEO_PREAMBLE; ctl0 = 2'b10; ctl1 = 2'b00; ctl2 = 2'b11;
        tick();
        chk("vpre_l0", sym0, 10'b0101010100);
        chk("vpre_l1", sym1, 10'b0010101011);
        chk("vpre_l2", sym2, 10'b1101010100);

        period = PERIOD_VIDEO_GUARD;
        tick();
        chk("vguard_l0", sym0, 10'b1011001100);
        chk("vguard_l1", sym1, 10'b0100110011);
        chk("vguard_l2", sym2, 10'b1011001100);

        period = PERIOD_VIDEO_ACTIVE; v0 = 8'h00; v1 = 8'h00; v2 = 8'hFF;
        tick();
        chk("vid00_l0", sym0, 10'b0100000000);
        chk("vid00_l1", sym1, 10'b0100000000);
        chk("vidFF_l2", sym2, 10'b1000000000);

        v0 = 8'h00; v1 = 8'hFF;
        tick();
        chk("vid00b_l0", sym0, 10'b1111111111);
        chk("vidFFc_l1", sym1, 10'b0011111111);

        period = PERIOD_CONTROL; ctl0 = 2'b00; ctl1 = 2'b00; ctl2 = 2'b00;
        tick();
        chk("back_ctl_l0", sym0, 10'b1101010100);

        period = PERIOD_VIDEO_ACTIVE; v0 = 8'h00; v1 = 8'h00; v2 = 8'h00;
        tick();
        chk("cnt_clr_l0", sym0, 10'b0100000000);
        chk("cnt_clr_l1", sym1, 10'b0100000000);
        chk("cnt_clr_l2", sym2, 10'b0100000000);

        rst_n = 1'b1;
        tick();
        chk("midrst_l0", sym0, 10'b1101010100);
        rst_n = 1'b0;
        tick();
        chk("after_rst_l0", sym0, 10'b0100000000);

        period = period_t'(3'd7); ctl0 = 2'b11;
        tick();
        chk("illegal_l0", sym0, 10'b1010101011);

        // Mixed per-lane traffic checked against the reference model.
        mcnt[0] = 0; mcnt[1] = 0; mcnt[2] = 0;
        period = PERIOD_VIDEO_ACTIVE;
        for (int k = 0; k < 24; k++) begin
            v0 = k[0] ? 8'h00 : 8'hFF;
            v1 = (k % 3 == 2) ? 8'h00 : 8'hFF;
            v2 = tbl[k % 16];
            e0 = ref_enc(v0, mcnt[0], c); mcnt[0] = c;
            e1 = ref_enc(v1, mcnt[1], c); mcnt[1] = c;
            e2 = ref_enc(v2, mcnt[2], c); mcnt[2] = c;
            tick();
            chk($sformatf("mix%0d_l0", k), sym0, e0);
            chk($sformatf("mix%0d_l1", k), sym1, e1);
            chk($sformatf("mix%0d_l2", k), sym2, e2);
        end

        period = PERIOD_CONTROL; ctl0 = 2'b00; ctl1 = 2'b01; ctl2 = 2'b10;
        tick();
        chk("mix_exit_l0", sym0, 10'b1101010100);
        chk("mix_exit_l1", sym1, 10'b0010101011);
        chk("mix_exit_l2", sym2, 10'b0101010100);

        period = PERIOD_VIDEO_ACTIVE; v0 = 8'h00; v1 = 8'h00; v2 = 8'hFF;
        tick();
        chk("mix_reent_l0", sym0, 10'b0100000000);
        chk("mix_reent_l1", sym1, 10'b0100000000);
        chk("mix_reent_l2", sym2, 10'b1000000000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
